operand_fetch: RTL

- Pipeline stage directly downstream of the instruction decoder and upstream of the execution units.
- Holds the 32x32 integer register file and a per-register scoreboard.
- Reads rs1/rs2, generates the sign-extended immediate and detects RAW/WAW hazards.
- Issues one registered operand bundle per cycle, or stalls the front end until the hazard clears.

---
 rtl/operand_fetch_if.sv | 66 ++++++
 rtl/operand_fetch.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/operand_fetch_if.sv
// operand_fetch_pkg / operand_fetch_if
// The package holds the decoded-instruction types that the decoder, the
// operand fetch stage and the execution units share.
// The interface groups every signal of the operand fetch stage except
// clk/reset.
//   master : decoder / writeback / execute side (drives the *_in, flush, wb_*)
//   slave  : operand_fetch (drives stall_out and the issued bundle)
// Handshake: the decoder offers a bundle with valid_in. The bundle is taken
// on a rising edge where valid_in=1, stall_out=0 and flush=0. While
// stall_out=1 the decoder must hold the bundle unchanged. valid_out has no
// back-pressure: an issued bundle is valid for exactly one cycle.
package operand_fetch_pkg;
  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmts;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_LUI, OP_AUIPC, OP_JAL
  } instruction_type;
  typedef enum logic [1:0] {XU_ALU, XU_LSU, XU_BRU} xu;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
endpackage

interface operand_fetch_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
);
  // decoder bundle
  logic                              valid_in;
  logic [4:0]                        regA;
  logic [4:0]                        regB;
  logic [4:0]                        regD;
  logic [XLEN-1:0]                   NPC_in;
  operand_fetch_pkg::fmts            fmt_in;
  logic [31:0]                       instruction_in;
  operand_fetch_pkg::instruction_type i_in;
  operand_fetch_pkg::xu              xu_sel_in;
  logic [TAG_W-1:0]                  tag_in;
  logic                              flush;
  // writeback port
  logic                              wb_we;
  logic [4:0]                        wb_addr;
  logic [XLEN-1:0]                   wb_data;
  // stage outputs
  logic                              stall_out;
  logic                              valid_out;
  logic [XLEN-1:0]                   opA;
  logic [XLEN-1:0]                   opB;
  logic [XLEN-1:0]                   imm_out;
  logic [4:0]                        regD_out;
  logic [XLEN-1:0]                   NPC_out;
  operand_fetch_pkg::instruction_type i_out;
  operand_fetch_pkg::xu              xu_sel_out;
  logic [TAG_W-1:0]                  tag_out;

  modport master (
    output valid_in, regA, regB, regD, NPC_in, fmt_in, instruction_in, i_in,
           xu_sel_in, tag_in, flush, wb_we, wb_addr, wb_data,
    input  stall_out, valid_out, opA, opB, imm_out, regD_out, NPC_out, i_out,
           xu_sel_out, tag_out
  );

  modport slave (
    input  valid_in, regA, regB, regD, NPC_in, fmt_in, instruction_in, i_in,
           xu_sel_in, tag_in, flush, wb_we, wb_addr, wb_data,
    output stall_out, valid_out, opA, opB, imm_out, regD_out, NPC_out, i_out,
           xu_sel_out, tag_out
  );
endinterface

// File: rtl/operand_fetch.sv
// operand_fetch
// Stage between the decoder and the execution units. Holds the 32xXLEN
// integer register file and a one-bit-per-register busy scoreboard, reads
// rs1/rs2 (with same-cycle writeback bypass), builds the sign-extended
// immediate, selects opA/opB, and either issues one registered bundle per
// cycle or stalls the decoder on a RAW/WAW hazard.
// Ports:
//   clk    clock
//   reset  asynchronous, active-low; clears regfile, scoreboard, outputs
//   bus    operand_fetch_if.slave (decoder bundle, flush, writeback, issue)
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input logic           clk,
  input logic           reset,
  operand_fetch_if.slave bus
);

  logic [XLEN-1:0] rf [32];
  logic [31:0]     lock;
  logic [31:0]     lock_n;
  logic [31:0]     wb_clr;
  logic [31:0]     lock_eff;

  logic            wb_hit;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic            use_rs1, use_rs2, wr_rd;
  logic            hazard, issue;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm, op_a, op_b, pc_cur;
  logic [31:0]     inst;

  assign inst   = bus.instruction_in;
  assign wb_hit = bus.wb_we && (bus.wb_addr != 5'd0);
  assign wb_clr = wb_hit ? (32'd1 << bus.wb_addr) : 32'd0;
  // A register being written back this cycle no longer blocks anyone.
  assign lock_eff = lock & ~wb_clr;

  // Register read with writeback bypass; x0 is hardwired to zero.
  function automatic logic [XLEN-1:0] rd_reg(input logic [4:0] a);
    if (a == 5'd0)                   return '0;
    else if (wb_hit && a == bus.wb_addr) return bus.wb_data;
    else                             return rf[a];
  endfunction

  always_comb begin
    rs1_data = rd_reg(bus.regA);
    rs2_data = rd_reg(bus.regB);
  end

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    wr_rd   = 1'b0;
    case (bus.fmt_in)
      FMT_R:   begin use_rs1 = 1'b1; use_rs2 = 1'b1; wr_rd = 1'b1; end
      FMT_I:   begin use_rs1 = 1'b1; wr_rd = 1'b1; end
      FMT_S,
      FMT_B:   begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
      FMT_U,
      FMT_J:   wr_rd = 1'b1;
      default: ;
    endcase
    // x0 is never locked, so writing it cannot create a WAW hazard.
    if (bus.regD == 5'd0) wr_rd = 1'b0;
  end

  assign hazard = (use_rs1 && lock_eff[bus.regA]) ||
                  (use_rs2 && lock_eff[bus.regB]) ||
                  (wr_rd   && lock_eff[bus.regD]);
  assign bus.stall_out = bus.valid_in && !bus.flush && hazard;
  assign issue         = bus.valid_in && !bus.flush && !hazard;

  always_comb begin
    imm32 = 32'd0;
    case (bus.fmt_in)
      FMT_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
      FMT_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                        inst[11:8], 1'b0};
      FMT_U:   imm32 = {inst[31:12], 12'd0};
      FMT_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                        inst[30:21], 1'b0};
      default: imm32 = 32'd0;
    endcase
    imm = XLEN'($signed(imm32));
  end

  // The decoder supplies PC+4; the instruction's own PC is one word back.
  assign pc_cur = bus.NPC_in - XLEN'(4);

  always_comb begin
    op_a = rs1_data;
    op_b = imm;
    case (bus.fmt_in)
      FMT_R, FMT_S, FMT_B: op_b = rs2_data;
      FMT_J:               op_a = pc_cur;
      FMT_U:               op_a = (inst[6:0] == OPC_AUIPC) ? pc_cur : '0;
      default:             ;
    endcase
  end

  // Clear from writeback first, then set from issue, so a same-cycle set wins.
  always_comb begin
    lock_n = lock & ~wb_clr;
    if (issue && wr_rd) lock_n[bus.regD] = 1'b1;
    lock_n[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < 32; r++) rf[r] <= '0;
      lock           <= '0;
      bus.valid_out  <= 1'b0;
      bus.opA        <= '0;
      bus.opB        <= '0;
      bus.imm_out    <= '0;
      bus.regD_out   <= '0;
      bus.NPC_out    <= '0;
      bus.i_out      <= OP_ADD;
      bus.xu_sel_out <= XU_ALU;
      bus.tag_out    <= '0;
    end else begin
      if (wb_hit) rf[bus.wb_addr] <= bus.wb_data;
      lock          <= lock_n;
      bus.valid_out <= issue;
      if (issue) begin
        bus.opA        <= op_a;
        bus.opB        <= op_b;
        bus.imm_out    <= imm;
        bus.regD_out   <= bus.regD;
        bus.NPC_out    <= bus.NPC_in;
        bus.i_out      <= bus.i_in;
        bus.xu_sel_out <= bus.xu_sel_in;
        bus.tag_out    <= bus.tag_in;
      end
    end
  end

endmodule
